// File: rtl/gpio_multi_bank_pkg.sv
// Shared constants for the multi-bank GPIO: register word indices,
// bus address field positions and the byte-lane mask helper.
package gpio_multi_bank_pkg;

    localparam int unsigned REG_IDX_W    = 10;
    localparam int unsigned BANK_FIELD_W = 4;

    localparam int unsigned ID_MSB   = 23;
    localparam int unsigned ID_LSB   = 16;
    localparam int unsigned BANK_MSB = 15;
    localparam int unsigned BANK_LSB = 12;
    localparam int unsigned REG_MSB  = 11;
    localparam int unsigned REG_LSB  = 2;

    // Word indices (byte offset >> 2) of the per-bank registers.
    localparam logic [REG_IDX_W-1:0] REG_OE         = 10'h000;
    localparam logic [REG_IDX_W-1:0] REG_OUTPUT     = 10'h001;
    localparam logic [REG_IDX_W-1:0] REG_INPUT      = 10'h002;
    localparam logic [REG_IDX_W-1:0] REG_SET        = 10'h003;
    localparam logic [REG_IDX_W-1:0] REG_CLEAR      = 10'h004;
    localparam logic [REG_IDX_W-1:0] REG_TOGGLE     = 10'h005;
    localparam logic [REG_IDX_W-1:0] REG_RISE_EN    = 10'h006;
    localparam logic [REG_IDX_W-1:0] REG_FALL_EN    = 10'h007;
    localparam logic [REG_IDX_W-1:0] REG_IRQ_STATUS = 10'h008;

    // Expand the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] byte_select);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{byte_select[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_bank.sv
// One GPIO bank: OE/OUTPUT registers with atomic set/clear/toggle,
// 2-flop input synchroniser, edge capture into sticky W1C status, irq flop.
module gpio_bank
    import gpio_multi_bank_pkg::*;
#(
    parameter int unsigned IO_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 bank_selected,
    input  logic [REG_IDX_W-1:0] reg_index,
    input  logic [3:0]           byte_select,
    input  logic [31:0]          data_write,
    input  logic [IO_WIDTH-1:0]  pin_input,
    output logic [IO_WIDTH-1:0]  pin_output,
    output logic [IO_WIDTH-1:0]  pin_oe,
    output logic                 irq,
    output logic [31:0]          data_read
);

    logic [IO_WIDTH-1:0] oe_q;
    logic [IO_WIDTH-1:0] out_q;
    logic [IO_WIDTH-1:0] rise_en_q;
    logic [IO_WIDTH-1:0] fall_en_q;
    logic [IO_WIDTH-1:0] status_q;
    logic [IO_WIDTH-1:0] sync1_q;
    logic [IO_WIDTH-1:0] sync2_q;
    logic [IO_WIDTH-1:0] prev_q;
    logic                irq_q;

    logic [31:0]         lane_bits;
    logic [IO_WIDTH-1:0] wmask;
    logic [IO_WIDTH-1:0] wdata;
    logic [IO_WIDTH-1:0] w1c;
    logic [IO_WIDTH-1:0] rise;
    logic [IO_WIDTH-1:0] fall;
    logic [IO_WIDTH-1:0] status_next;
    logic                wr;
    logic                unused_hi;

    // Bits above IO_WIDTH are simply dropped on write.
    assign unused_hi = ^{data_write, lane_bits};

    // Masked write data, W1C vector, edge events and next status.
    always_comb begin
        lane_bits   = lane_mask(byte_select);
        wmask       = lane_bits[IO_WIDTH-1:0];
        wdata       = data_write[IO_WIDTH-1:0] & wmask;
        wr          = we && bank_selected;
        w1c         = (wr && (reg_index == REG_IRQ_STATUS)) ? wdata : '0;
        rise        = sync2_q & ~prev_q;
        fall        = ~sync2_q & prev_q;
        // Event terms are OR-ed after the clear so a same-cycle edge wins.
        status_next = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Register state, synchroniser chain, status and irq flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oe_q      <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q  <= pin_input;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            status_q <= status_next;
            irq_q    <= |status_q;
            if (wr) begin
                case (reg_index)
                    REG_OE:      oe_q      <= (oe_q & ~wmask) | wdata;
                    REG_OUTPUT:  out_q     <= (out_q & ~wmask) | wdata;
                    REG_SET:     out_q     <= out_q | wdata;
                    REG_CLEAR:   out_q     <= out_q & ~wdata;
                    REG_TOGGLE:  out_q     <= out_q ^ wdata;
                    REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wdata;
                    REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wdata;
                    default: ;
                endcase
            end
        end
    end

    // Register read mux; write-only and unmapped offsets read as 0.
    always_comb begin
        data_read = '0;
        case (reg_index)
            REG_OE:         data_read[IO_WIDTH-1:0] = oe_q;
            REG_OUTPUT:     data_read[IO_WIDTH-1:0] = out_q;
            REG_INPUT:      data_read[IO_WIDTH-1:0] = sync2_q;
            REG_RISE_EN:    data_read[IO_WIDTH-1:0] = rise_en_q;
            REG_FALL_EN:    data_read[IO_WIDTH-1:0] = fall_en_q;
            REG_IRQ_STATUS: data_read[IO_WIDTH-1:0] = status_q;
            default:        data_read = '0;
        endcase
    end

    assign pin_output = out_q;
    assign pin_oe     = oe_q;
    assign irq        = irq_q;

endmodule

// File: rtl/gpio_multi_bank.sv
// Multi-bank GPIO peripheral: peripheral/bank decode, per-bank instances
// and the combinational read-data mux.
module gpio_multi_bank
    import gpio_multi_bank_pkg::*;
#(
    parameter logic [7:0]  ID         = 8'h03,
    parameter int unsigned BANK_COUNT = 2,
    parameter int unsigned IO_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           peripheralBus_we,
    input  logic                           peripheralBus_oe,
    output logic                           peripheralBus_busy,
    input  logic [23:0]                    peripheralBus_address,
    input  logic [3:0]                     peripheralBus_byteSelect,
    input  logic [31:0]                    peripheralBus_dataWrite,
    output logic [31:0]                    peripheralBus_dataRead,
    output logic                           requestOutput,
    input  logic [BANK_COUNT*IO_WIDTH-1:0] gpio_input,
    output logic [BANK_COUNT*IO_WIDTH-1:0] gpio_output,
    output logic [BANK_COUNT*IO_WIDTH-1:0] gpio_oe,
    output logic [BANK_COUNT-1:0]          gpio_irq
);

    logic                    id_hit;
    logic [BANK_FIELD_W-1:0] bank_field;
    logic [REG_IDX_W-1:0]    reg_index;
    logic [BANK_COUNT-1:0]   bank_sel;
    logic [31:0]             bank_read [BANK_COUNT];
    logic                    unused_addr;

    assign peripheralBus_busy = 1'b0;
    assign unused_addr        = ^peripheralBus_address[1:0];

    // Split the byte address into peripheral id, bank field and register.
    always_comb begin
        id_hit     = (peripheralBus_address[ID_MSB:ID_LSB] == ID);
        bank_field = peripheralBus_address[BANK_MSB:BANK_LSB];
        reg_index  = peripheralBus_address[REG_MSB:REG_LSB];
    end

    for (genvar b = 0; b < int'(BANK_COUNT); b++) begin : g_bank
        // Bank field value 0 is unmapped; bank b answers to field b+1.
        localparam logic [BANK_FIELD_W-1:0] BANK_CODE = BANK_FIELD_W'(b + 1);

        assign bank_sel[b] = id_hit && (bank_field == BANK_CODE);

        gpio_bank #(
            .IO_WIDTH(IO_WIDTH)
        ) u_bank (
            .clk           (clk),
            .rst           (rst),
            .we            (peripheralBus_we),
            .bank_selected (bank_sel[b]),
            .reg_index     (reg_index),
            .byte_select   (peripheralBus_byteSelect),
            .data_write    (peripheralBus_dataWrite),
            .pin_input     (gpio_input[b*IO_WIDTH +: IO_WIDTH]),
            .pin_output    (gpio_output[b*IO_WIDTH +: IO_WIDTH]),
            .pin_oe        (gpio_oe[b*IO_WIDTH +: IO_WIDTH]),
            .irq           (gpio_irq[b]),
            .data_read     (bank_read[b])
        );
    end

    // Read response: any selected read is claimed, unmapped banks return 0.
    always_comb begin
        requestOutput          = id_hit && peripheralBus_oe && !peripheralBus_we;
        peripheralBus_dataRead = '0;
        if (requestOutput) begin
            for (int unsigned b = 0; b < BANK_COUNT; b++) begin
                if (bank_sel[b]) begin
                    peripheralBus_dataRead = bank_read[b];
                end
            end
        end
    end

endmodule

// File: doc/gpio_multi_bank.md
Name: gpio_multi_bank

Overview:
- Parametrised successor to the two-bank GPIO peripheral. Provides BANK_COUNT identical banks of IO_WIDTH pins each on the shared peripheral bus.
- Adds per-bank atomic set/clear/toggle, 2-flop input synchronisation, rising/falling edge capture with sticky write-1-to-clear status, and a per-bank interrupt line.
- Sits beside the other peripherals behind the core's peripheral bus. Pads connect through flattened input/output/oe vectors.

Parameters:
- ID, 8'h03, peripheral select value compared against peripheralBus_address[23:16].
- BANK_COUNT, 2, number of banks. Legal range 1..15.
- IO_WIDTH, 32, pins per bank. Legal range 1..32.

Ports:
- clk  input  1  system clock; every flop is on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- peripheralBus_we  input  1  write strobe.
- peripheralBus_oe  input  1  read strobe.
- peripheralBus_busy  output  1  held at 0; there are no wait states.
- peripheralBus_address  input  24  byte address.
- peripheralBus_byteSelect  input  4  byte lane enables for writes.
- peripheralBus_dataWrite  input  32  write data.
- peripheralBus_dataRead  output  32  read data. 0 unless requestOutput is 1.
- requestOutput  output  1  this block is driving read data this cycle.
- gpio_input  input  BANK_COUNT*IO_WIDTH  pad inputs. Bank b occupies bits [b*IO_WIDTH +: IO_WIDTH].
- gpio_output  output  BANK_COUNT*IO_WIDTH  pad output values.
- gpio_oe  output  BANK_COUNT*IO_WIDTH  pad output enables (1 = drive).
- gpio_irq  output  BANK_COUNT  per-bank interrupt, registered.

Behaviour:
- Address decode:
  - Peripheral is selected when address[23:16]==ID.
  - Bank index b = address[15:12]-1; valid for address[15:12] in 1..BANK_COUNT.
  - Register = address[11:2]. address[1:0] is ignored.
  - Unmapped bank or register: reads return 0 with requestOutput still 1; writes are ignored.
- Register map (offset, access, reset value):
  - 0x00 OE, RW, 0.
  - 0x04 OUTPUT, RW, 0.
  - 0x08 INPUT, RO, synchronised pin value.
  - 0x0C SET, WO: OUTPUT |= data.
  - 0x10 CLEAR, WO: OUTPUT &= ~data.
  - 0x14 TOGGLE, WO: OUTPUT ^= data.
  - 0x18 RISE_EN, RW, 0.
  - 0x1C FALL_EN, RW, 0.
  - 0x20 IRQ_STATUS, RW1C, 0.
  - WO registers read as 0.
- Writes:
  - Take effect on the clk edge where we=1 and the address is selected.
  - Only lanes with byteSelect[i]=1 modify bits [8i+7:8i]. Masked lanes are treated as data 0 for SET/CLEAR/TOGGLE/W1C.
  - Bits >= IO_WIDTH are ignored on write and read back as 0.
- Reads: combinational. requestOutput = selected && oe && !we. The block never drives read data on a write cycle.
- Input path:
  - Pins go through 2 flops (sync1, sync2), then a prev flop holding the last sync2 value.
  - INPUT reads sync2, so a pin change is visible 2 cycles after it is sampled.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- IRQ_STATUS update: next = (status & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - When an edge event and a W1C hit the same bit in the same cycle, the event wins and the bit stays 1.
- gpio_irq[b] is a flop of |IRQ_STATUS[b]. It rises 1 cycle after the status bit sets and falls 1 cycle after the last bit clears.
- Enable changes:
  - Changing RISE_EN or FALL_EN does not alter bits already set.
  - Enabling a pin while it is already high produces no event; only transitions after the enable count.
- Reset (rst==0 at a clk edge):
  - OE, OUTPUT, RISE_EN, FALL_EN, IRQ_STATUS, gpio_irq and all sync/prev flops go to 0.
  - gpio_output = 0, gpio_oe = 0, gpio_irq = 0 from the next edge onward.
  - Bus writes during reset are ignored.
  - A pin that is high when reset releases takes 2 cycles to load through sync1/sync2. Until then prev (0) differs from sync2, so a pin held high across reset release may set a rise bit once. This is acceptable only if RISE_EN is set, and RISE_EN is 0 after reset, so in practice no event results.
- Simultaneous bus write and internal update: there is a single write port per cycle, so no other conflict exists beyond the W1C/event rule above.

Decomposition:
- Package gpio_multi_bank_pkg holds the register offset constants (REG_OE … REG_IRQ_STATUS), the address field positions and the bank-field width.
- Sub-module gpio_bank, one per bank via generate:
  - Contains the registers, synchroniser, edge detect, W1C logic and irq flop.
  - Inputs: bus strobes, bankSelected, register index, byteSelect, write data.
  - Outputs: read data for that bank.
- The top level does the ID/bank decode, the read mux and requestOutput.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random pins and bus writes -> gpio_output=0, gpio_oe=0, gpio_irq=0; all RW registers read 0 after release.
- Byte lanes and atomics, bank 2 (addr 0x03_2000): write OUTPUT=0xFFFF_FFFF with byteSelect=4'b0101 -> OUTPUT reads 0x00FF_00FF. Then SET 0x0000_FF00 -> 0x00FF_FFFF. CLEAR 0x0000_000F -> 0x00FF_FFF0. TOGGLE 0xF000_0000 -> 0xF0FF_FFF0.
- Sync latency: drive gpio_input bank 1 bit 3 from 0 to 1 -> INPUT bit 3 reads 1 exactly 2 cycles later.
- Edge IRQ: RISE_EN=0x8, FALL_EN=0x0, pulse pin 3 high -> IRQ_STATUS=0x8 and gpio_irq[0]=1 one cycle later; the falling edge adds nothing. Write 0x8 to IRQ_STATUS -> status 0, irq low on the next cycle.
- Collision: W1C of bit 3 in the same cycle as a new rise on bit 3 -> bit stays 1 and irq stays 1.
- Decode and width: with IO_WIDTH=6 and BANK_COUNT=2, write 0xFF to OUTPUT -> reads 0x3F. A read at bank field 3 or register 0x24 -> requestOutput=1, data 0. A read with address[23:16]=0x04 -> requestOutput=0, dataRead=0.
